// File: rtl/vram_pkg.sv
// Shared VRAM geometry constants and small helpers for the write arbiter.
package vram_pkg;

  localparam int VRAM_NUM_REQ  = 16;
  localparam int VRAM_ADDR_W   = 18;
  localparam int VRAM_DATA_W   = 8;
  localparam int VRAM_FB_WORDS = 76800;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic in_fb(input logic [31:0] addr, input logic [31:0] limit);
    return addr < limit;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import vram_pkg::*;
#(
  parameter  int NUM_REQ = VRAM_NUM_REQ,
  localparam int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  int   cand;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates per-core pixel writes into a single registered VRAM write port.
// Define VRAM_ARB_STATS_EN to build the write/drop statistics counters.
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int NUM_REQ  = VRAM_NUM_REQ,
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int FB_WORDS = VRAM_FB_WORDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      mem_valid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data,
  input  logic                      mem_ready,
  output logic                      err_oob,
  output logic [31:0]               stat_writes,
  output logic [15:0]               stat_drops
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_data_q, mem_data_d;
  logic               err_oob_q, err_oob_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               out_free;
  logic               xfer;
  logic               in_range;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // The output slot can take a new write when empty or being drained this cycle.
  assign out_free  = ~mem_valid_q | mem_ready;
  assign req_ready = (out_free && !reset) ? gnt : '0;
  assign xfer      = |req_ready;
  assign sel_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[gnt_idx*DATA_W +: DATA_W];
  assign in_range  = in_fb(32'(sel_addr), 32'(FB_WORDS));

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    err_oob_d   = 1'b0;
    if (mem_valid_q && mem_ready) begin
      mem_valid_d = 1'b0;
    end
    if (xfer) begin
      rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      if (in_range) begin
        mem_valid_d = 1'b1;
        mem_addr_d  = sel_addr;
        mem_data_d  = sel_data;
      end else begin
        err_oob_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      err_oob_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      err_oob_q   <= err_oob_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign err_oob   = err_oob_q;

`ifdef VRAM_ARB_STATS_EN
  logic [31:0] stat_writes_q, stat_writes_d;
  logic [15:0] stat_drops_q, stat_drops_d;

  // Write count wraps; drop count sticks at all-ones.
  always_comb begin
    stat_writes_d = stat_writes_q;
    stat_drops_d  = stat_drops_q;
    if (mem_valid_q && mem_ready) begin
      stat_writes_d = stat_writes_q + 32'd1;
    end
    if (xfer && !in_range && (stat_drops_q != 16'hFFFF)) begin
      stat_drops_d = stat_drops_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_writes_q <= '0;
      stat_drops_q  <= '0;
    end else begin
      stat_writes_q <= stat_writes_d;
      stat_drops_q  <= stat_drops_d;
    end
  end

  assign stat_writes = stat_writes_q;
  assign stat_drops  = stat_drops_q;
`else
  assign stat_writes = '0;
  assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: a reference model predicts grants and writes.
module tb_vram_write_arbiter;

  localparam int N   = 16;
  localparam int AW  = 18;
  localparam int DW  = 8;
  localparam int FBW = 76800;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              mem_valid;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic              mem_ready;
  logic              err_oob;
  logic [31:0]       stat_writes;
  logic [15:0]       stat_drops;

  logic [AW-1:0]     addr_a [N];
  logic [DW-1:0]     data_a [N];

  int                checks = 0;
  int                errors = 0;
  int                m_ptr;
  bit                m_valid;
  bit                m_err;
  int unsigned       m_writes;
  int                m_drops;
  logic [AW+DW-1:0]  sb [$];
  int                gnt_log [$];
  int                obs_writes = 0;
  int                w0;

  vram_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .err_oob     (err_oob),
    .stat_writes (stat_writes),
    .stat_drops  (stat_drops)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr_a[i];
      req_data[i*DW +: DW] = data_a[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  task automatic chk_gnt(input string tag, input int k, input int exp);
    if (gnt_log.size() <= k) chk(tag, 32'hFFFF_FFFF, 32'(exp));
    else chk(tag, 32'(gnt_log[k]), 32'(exp));
  endtask

  task automatic m_reset();
    m_ptr    = 0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_writes = 0;
    m_drops  = 0;
    sb.delete();
  endtask

  // One clock: check outputs at the falling edge, advance the model, return at posedge+1.
  task automatic step();
    int           w;
    bit           free;
    bit           err_n;
    logic [N-1:0] er;
    logic [AW+DW-1:0] e;
    @(negedge clk);
    free = !m_valid || mem_ready;
    w = -1;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && req_valid[j]) w = j;
      end
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    if (req_ready != '0) gnt_log.push_back(oh_idx(req_ready));
    chk("mem_valid", 32'(mem_valid), 32'(m_valid));
    chk("err_oob", 32'(err_oob), 32'(m_err));
`ifdef VRAM_ARB_STATS_EN
    chk("stat_writes", stat_writes, m_writes);
    chk("stat_drops", 32'(stat_drops), 32'(m_drops));
`else
    chk("stat_writes", stat_writes, 32'd0);
    chk("stat_drops", 32'(stat_drops), 32'd0);
`endif
    if (mem_valid && mem_ready) obs_writes++;
    if (m_valid && mem_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
        chk("mem_data", 32'(mem_data), 32'(e[DW-1:0]));
      end
      m_writes++;
      m_valid = 1'b0;
    end
    err_n = 1'b0;
    if (w >= 0) begin
      if (int'(addr_a[w]) < FBW) begin
        sb.push_back({addr_a[w], data_a[w]});
        m_valid = 1'b1;
      end else begin
        err_n = 1'b1;
        if (m_drops != 65535) m_drops++;
      end
      m_ptr = (w + 1) % N;
    end
    m_err = err_n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_err_oob", 32'(err_oob), 32'd0);
    chk("rst_stat_writes", stat_writes, 32'd0);
    chk("rst_stat_drops", 32'(stat_drops), 32'd0);
    m_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '1;
    mem_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'(i * 3 + 32'h200);
      data_a[i] = DW'(i + 32'h10);
    end
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_req_ready", 32'(req_ready), 32'd0);
    chk("init_mem_valid", 32'(mem_valid), 32'd0);
    chk("init_mem_addr", 32'(mem_addr), 32'd0);
    chk("init_err_oob", 32'(err_oob), 32'd0);
    chk("init_stat_writes", stat_writes, 32'd0);
    reset     = 1'b0;
    req_valid = '0;

    // Reset while a write is stalled; pending write is discarded.
    addr_a[1] = AW'(10);
    data_a[1] = DW'(8'h11);
    req_valid = 16'h0002;
    mem_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    chk("stalled_before_rst", 32'(mem_valid), 32'd1);
    do_reset();
    req_valid = 16'h0011;
    mem_ready = 1'b1;
    gnt_log.delete();
    step();
    chk_gnt("post_rst_gnt", 0, 0);
    req_valid = '0;
    step();

    // Move pointer to 0, then full-load round robin.
    req_valid = 16'h8000;
    step();
    req_valid = '0;
    step();
    req_valid = '1;
    gnt_log.delete();
    w0 = obs_writes;
    repeat (17) step();
    req_valid = '0;
    step();
    for (int k = 0; k < 17; k++) chk_gnt($sformatf("burst_gnt%0d", k), k, k % 16);
    chk("burst_writes", 32'(obs_writes - w0), 32'd17);

    // Backpressure: write from core 5 held while mem_ready is low.
    addr_a[5] = AW'(18'h00100);
    data_a[5] = DW'(8'hA5);
    req_valid = 16'h0020;
    mem_ready = 1'b0;
    gnt_log.delete();
    step();
    req_valid = 16'h0040;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", 32'(mem_valid), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'h100);
      chk("stall_data", 32'(mem_data), 32'hA5);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    mem_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    chk("stall_gnt_count", 32'(gnt_log.size()), 32'd2);
    chk_gnt("stall_gnt0", 0, 5);
    chk_gnt("stall_gnt1", 1, 6);

    // Out-of-range write from core 3 is accepted and dropped.
    addr_a[3] = AW'(FBW);
    req_valid = 16'h0008;
    gnt_log.delete();
    step();
    chk_gnt("oob_gnt", 0, 3);
    chk("oob_err_pulse", 32'(err_oob), 32'd1);
    chk("oob_no_write", 32'(mem_valid), 32'd0);
    req_valid = '0;
    step();
    chk("oob_err_clear", 32'(err_oob), 32'd0);
`ifdef VRAM_ARB_STATS_EN
    chk("oob_drops", 32'(stat_drops), 32'd1);
`else
    chk("oob_drops", 32'(stat_drops), 32'd0);
`endif
    addr_a[3] = AW'(FBW - 1);
    req_valid = 16'h0008;
    step();
    req_valid = '0;
    step();

    // Wrap from pointer 15: grant 15, then 2, pointer ends at 3.
    req_valid = 16'h4000;
    step();
    req_valid = 16'h8004;
    gnt_log.delete();
    step();
    step();
    req_valid = 16'h0014;
    step();
    req_valid = '0;
    step();
    chk_gnt("wrap_gnt15", 0, 15);
    chk_gnt("wrap_gnt2", 1, 2);
    chk_gnt("wrap_ptr3", 2, 4);

    // Random traffic with backpressure and out-of-range addresses.
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        addr_a[i] = ($urandom_range(0, 3) == 0) ? AW'(FBW + $urandom_range(0, 1000))
                                                 : AW'($urandom_range(0, FBW - 1));
        data_a[i] = DW'($urandom);
      end
      step();
    end
    req_valid = '0;
    mem_ready = 1'b1;
    step();
    step();
    chk("random_sb_empty", 32'(sb.size()), 32'd0);

    // Long run for the write counter.
    do_reset();
    for (int i = 0; i < N; i++) addr_a[i] = AW'(i * 7);
    req_valid = '1;
    mem_ready = 1'b1;
    repeat (70000) step();
    req_valid = '0;
    step();
`ifdef VRAM_ARB_STATS_EN
    chk("long_stat_writes", stat_writes, 32'd70000);
`else
    chk("long_stat_writes", stat_writes, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
